// File: rtl/serial_magnitude_comparator.sv
// Bit-serial unsigned magnitude comparator: two operands arrive MSB-first, one bit pair
// per valid beat, and eq/gt/lt are reported with a one-cycle done pulse after the last bit.
module serial_magnitude_comparator #(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          bit_valid,
  input  logic          a_bit,
  input  logic          b_bit,
  output logic          busy,
  output logic          done,
  output logic          eq,
  output logic          gt,
  output logic          lt,
  output logic [CW-1:0] bit_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t state, state_n;

  logic decided;
  logic gt_int;
  logic lt_int;

  logic accept_start;
  logic consume;
  logic last_bit;
  logic decided_n;
  logic gt_n;
  logic lt_n;

  always_comb begin
    state_n      = state;
    accept_start = 1'b0;
    consume      = 1'b0;
    last_bit     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n      = COMPARE;
          accept_start = 1'b1;
        end
      end
      COMPARE: begin
        if (bit_valid) begin
          consume = 1'b1;
          if (bit_count == CW'(WIDTH - 1)) begin
            last_bit = 1'b1;
            state_n  = DONE;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // The first differing bit from the MSB decides; later bits cannot override it.
  always_comb begin
    decided_n = decided;
    gt_n      = gt_int;
    lt_n      = lt_int;
    if (!decided && (a_bit != b_bit)) begin
      decided_n = 1'b1;
      gt_n      = a_bit;
      lt_n      = b_bit;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      eq        <= 1'b0;
      gt        <= 1'b0;
      lt        <= 1'b0;
      bit_count <= '0;
      decided   <= 1'b0;
      gt_int    <= 1'b0;
      lt_int    <= 1'b0;
    end else begin
      state <= state_n;
      busy  <= (state_n == COMPARE);
      done  <= (state_n == DONE);
      if (accept_start) begin
        bit_count <= '0;
        decided   <= 1'b0;
        gt_int    <= 1'b0;
        lt_int    <= 1'b0;
        eq        <= 1'b0;
        gt        <= 1'b0;
        lt        <= 1'b0;
      end else if (consume) begin
        // The counter is forced to zero after the final bit so non-power-of-two widths wrap too.
        bit_count <= last_bit ? '0 : bit_count + CW'(1);
        decided   <= decided_n;
        gt_int    <= gt_n;
        lt_int    <= lt_n;
        if (last_bit) begin
          eq <= ~decided_n;
          gt <= gt_n;
          lt <= lt_n;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed bench for serial_magnitude_comparator at WIDTH=8.
module tb_serial_magnitude_comparator;

  localparam int WIDTH = 8;
  localparam int CW    = $clog2(WIDTH);

  logic          clk;
  logic          rst;
  logic          start;
  logic          bit_valid;
  logic          a_bit;
  logic          b_bit;
  logic          busy;
  logic          done;
  logic          eq;
  logic          gt;
  logic          lt;
  logic [CW-1:0] bit_count;

  int checks;
  int failures;

  serial_magnitude_comparator #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bit_valid (bit_valid),
    .a_bit     (a_bit),
    .b_bit     (b_bit),
    .busy      (busy),
    .done      (done),
    .eq        (eq),
    .gt        (gt),
    .lt        (lt),
    .bit_count (bit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one comparison. lat counts rising edges from the cycle start is driven until
  // done is seen. Optional: bit pair alongside start, a 2nd start after bit 4, and
  // gaps of gap_len idle cycles after bits 2 and 5 (gap_bad counts bit_count drift).
  task automatic run_cmp(input logic [7:0] a, input logic [7:0] b,
                         input bit vld_with_start, input bit mid_start, input int gap_len,
                         output int lat, output bit seen,
                         output logic r_eq, output logic r_gt, output logic r_lt,
                         output logic r_cnt, output logic after_done, output int gap_bad,
                         output int busy_bad);
    int n;
    lat = 0; seen = 0; gap_bad = 0; busy_bad = 0;
    r_eq = 0; r_gt = 0; r_lt = 0; r_cnt = 1'b1; after_done = 1'b1;
    @(negedge clk);
    start = 1'b1; bit_valid = vld_with_start; a_bit = 1'b1; b_bit = 1'b0;
    @(posedge clk); lat++;
    for (int i = 7; i >= 0; i--) begin
      n = 8 - i;
      @(negedge clk);
      if (busy !== 1'b1) busy_bad++;
      start = (mid_start && n == 5);
      bit_valid = 1'b1; a_bit = a[i]; b_bit = b[i];
      @(posedge clk); lat++;
      if (gap_len > 0 && (n == 2 || n == 5)) begin
        for (int g = 0; g < gap_len; g++) begin
          @(negedge clk);
          start = 1'b0; bit_valid = 1'b0; a_bit = ~a_bit; b_bit = ~b_bit;
          if (bit_count !== CW'(n) || busy !== 1'b1) gap_bad++;
          @(posedge clk); lat++;
        end
      end
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      start = 1'b0; bit_valid = 1'b0;
      if (done === 1'b1) begin
        seen = 1; r_eq = eq; r_gt = gt; r_lt = lt; r_cnt = |bit_count;
        if (busy !== 1'b0) busy_bad++;
        break;
      end
      @(posedge clk); lat++;
    end
    @(negedge clk);
    after_done = done;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; bit_valid = 0; a_bit = 0; b_bit = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, eq, gt, lt} !== 5'b0 || bit_count !== '0) begin
      failures++;
      $display("FAIL reset_state: got busy=%b done=%b eq=%b gt=%b lt=%b cnt=%0d, want all 0",
               busy, done, eq, gt, lt, bit_count);
    end
  endtask

  task automatic test_equal();
    int lat, gb, bb; bit seen; logic e, g, l, c, ad;
    run_cmp(8'hA5, 8'hA5, 0, 0, 0, lat, seen, e, g, l, c, ad, gb, bb);
    checks++;
    if (!seen || lat != 9) begin
      failures++;
      $display("FAIL eq_latency: got seen=%0d lat=%0d, want seen=1 lat=9", seen, lat);
    end
    checks++;
    if ({e, g, l} !== 3'b100) begin
      failures++;
      $display("FAIL eq_result: got eq/gt/lt=%b%b%b, want 100", e, g, l);
    end
    checks++;
    if (c !== 1'b0 || ad !== 1'b0 || bb != 0) begin
      failures++;
      $display("FAIL eq_done_shape: got cnt_nz=%b done_next=%b busy_bad=%0d, want 0 0 0", c, ad, bb);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({eq, gt, lt, busy, done} !== 5'b10000) begin
      failures++;
      $display("FAIL eq_hold: got eq/gt/lt/busy/done=%b%b%b%b%b, want 10000", eq, gt, lt, busy, done);
    end
  endtask

  task automatic test_msb_decides();
    int lat, gb, bb; bit seen; logic e, g, l, c, ad;
    run_cmp(8'h80, 8'h7F, 0, 0, 0, lat, seen, e, g, l, c, ad, gb, bb);
    checks++;
    if (!seen || {e, g, l} !== 3'b010) begin
      failures++;
      $display("FAIL msb_gt: got seen=%0d eq/gt/lt=%b%b%b, want 1 010", seen, e, g, l);
    end
    checks++;
    if (lat != 9) begin
      failures++;
      $display("FAIL msb_latency: got %0d, want 9", lat);
    end
  endtask

  task automatic test_stall();
    int lat, gb, bb; bit seen; logic e, g, l, c, ad;
    run_cmp(8'h3C, 8'h3D, 0, 0, 3, lat, seen, e, g, l, c, ad, gb, bb);
    checks++;
    if (!seen || {e, g, l} !== 3'b001) begin
      failures++;
      $display("FAIL stall_lt: got seen=%0d eq/gt/lt=%b%b%b, want 1 001", seen, e, g, l);
    end
    checks++;
    if (lat != 15) begin
      failures++;
      $display("FAIL stall_latency: got %0d, want 15", lat);
    end
    checks++;
    if (gb != 0) begin
      failures++;
      $display("FAIL stall_count_hold: got %0d bad gap cycles, want 0", gb);
    end
  endtask

  task automatic test_ignored_start();
    int lat, gb, bb; bit seen; logic e, g, l, c, ad;
    // A consumed idle pair (1 vs 0) would flip this to gt; a restart would stretch the latency.
    run_cmp(8'h12, 8'h34, 1, 1, 0, lat, seen, e, g, l, c, ad, gb, bb);
    checks++;
    if (!seen || {e, g, l} !== 3'b001) begin
      failures++;
      $display("FAIL ignore_result: got seen=%0d eq/gt/lt=%b%b%b, want 1 001", seen, e, g, l);
    end
    checks++;
    if (lat != 9 || bb != 0) begin
      failures++;
      $display("FAIL ignore_latency: got lat=%0d busy_bad=%0d, want 9 0", lat, bb);
    end
  endtask

  task automatic test_async_reset();
    int lat, gb, bb, done_cnt; bit seen; logic e, g, l, c, ad;
    logic [7:0] a, b;
    a = 8'hFF; b = 8'h00;
    @(negedge clk);
    start = 1'b1; bit_valid = 1'b0;
    @(posedge clk);
    for (int i = 7; i >= 4; i--) begin
      @(negedge clk);
      start = 1'b0; bit_valid = 1'b1; a_bit = a[i]; b_bit = b[i];
      @(posedge clk);
    end
    @(negedge clk);
    a_bit = a[3]; b_bit = b[3];
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, eq, gt, lt} !== 5'b0 || bit_count !== '0) begin
      failures++;
      $display("FAIL async_reset: got busy=%b done=%b eq=%b gt=%b lt=%b cnt=%0d, want all 0",
               busy, done, eq, gt, lt, bit_count);
    end
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) done_cnt++;
    end
    bit_valid = 1'b0;
    checks++;
    if (done_cnt != 0) begin
      failures++;
      $display("FAIL reset_no_done: got %0d cycles with done/busy, want 0", done_cnt);
    end
    run_cmp(8'h01, 8'h01, 0, 0, 0, lat, seen, e, g, l, c, ad, gb, bb);
    checks++;
    if (!seen || {e, g, l} !== 3'b100) begin
      failures++;
      $display("FAIL post_reset_eq: got seen=%0d eq/gt/lt=%b%b%b, want 1 100", seen, e, g, l);
    end
  endtask

  task automatic test_back_to_back();
    int lat, gb, bb; bit seen; logic e, g, l, c, ad;
    run_cmp(8'h01, 8'h00, 0, 0, 0, lat, seen, e, g, l, c, ad, gb, bb);
    checks++;
    if (!seen || {e, g, l} !== 3'b010) begin
      failures++;
      $display("FAIL lsb_gt: got seen=%0d eq/gt/lt=%b%b%b, want 1 010", seen, e, g, l);
    end
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({eq, gt, lt} !== 3'b000 || busy !== 1'b1 || bit_count !== '0) begin
      failures++;
      $display("FAIL start_clears: got eq/gt/lt=%b%b%b busy=%b cnt=%0d, want 000 1 0",
               eq, gt, lt, busy, bit_count);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; start = 0; bit_valid = 0; a_bit = 0; b_bit = 0;
    test_reset();
    test_equal();
    test_msb_decides();
    test_stall();
    test_ignored_start();
    test_async_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
